// File: rtl/bus_pkg.sv
// Shared address map, STATUS bit positions and decode helper for the data bus responder.
// Contents:
//   Word* : word addresses (byte address >> 2) of the MMIO registers
//   Status*Bit : bit positions inside the STATUS register
//   region_e / decode_region() : classify a word address into a target region
package bus_pkg;

  localparam logic [29:0] WordTxData    = 30'h0400_0000;  // 0x1000_0000
  localparam logic [29:0] WordStatus    = 30'h0400_0001;  // 0x1000_0004
  localparam logic [29:0] WordMtimeLo   = 30'h0400_0002;  // 0x1000_0008
  localparam logic [29:0] WordMtimeHi   = 30'h0400_0003;  // 0x1000_000C
  localparam logic [29:0] WordMtimecmpLo = 30'h0400_0004; // 0x1000_0010
  localparam logic [29:0] WordMtimecmpHi = 30'h0400_0005; // 0x1000_0014

  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusIrqBit   = 2;
  localparam int unsigned StatusOvfBit   = 3;

  typedef enum logic [2:0] {
    RegNone,
    RegRam,
    RegTxData,
    RegStatus,
    RegMtimeLo,
    RegMtimeHi,
    RegCmpLo,
    RegCmpHi
  } region_e;

  // RAM occupies word addresses 0 .. ram_words-1; everything not listed is unmapped.
  function automatic region_e decode_region(input logic [29:0] word,
                                            input int unsigned ram_words);
    region_e r;
    r = RegNone;
    if ({2'b00, word} < ram_words) begin
      r = RegRam;
    end else begin
      case (word)
        WordTxData:     r = RegTxData;
        WordStatus:     r = RegStatus;
        WordMtimeLo:    r = RegMtimeLo;
        WordMtimeHi:    r = RegMtimeHi;
        WordMtimecmpLo: r = RegCmpLo;
        WordMtimecmpHi: r = RegCmpHi;
        default:        r = RegNone;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the console transmit queue.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset (empties the queue)
//   push_i, data_i : enqueue request and data (ignored when full unless popping)
//   pop_i          : dequeue request (ignored when empty)
//   data_o         : head entry, zero while empty
//   empty_o, full_o: occupancy flags
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));

  // A push into a full queue is accepted only when a pop frees a slot in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Gating by empty keeps the head at zero after reset without clearing storage.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Bus target for a simple core: word RAM, console TX queue, STATUS and a 64-bit timer.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   bus_mem_read, bus_mem_write      : access strobes
//   bus_addr_in, bus_data_in         : byte address and write data
//   bus_byteen                       : byte-lane write enables
//   bus_data_out                     : combinational read data (zero when idle or unmapped)
//   tx_data, tx_valid, tx_ready      : console byte stream (valid/ready)
//   timer_irq                        : registered MTIME >= MTIMECMP
//   bus_error                        : one-cycle pulse after a bad access
module data_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_mem_read,
  input  logic             bus_mem_write,
  input  logic [WIDTH-1:0] bus_addr_in,
  input  logic [WIDTH-1:0] bus_data_in,
  input  logic [3:0]       bus_byteen,
  output logic [WIDTH-1:0] bus_data_out,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             timer_irq,
  output logic             bus_error
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);

  region_e          region;
  logic [RamAw-1:0] ram_idx;
  logic [WIDTH-1:0] ram_q [RAM_WORDS];
  logic             ram_we;

  logic [63:0] mtime_q, mtime_d;
  logic [31:0] shadow_q, shadow_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic        tx_push_req, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]  fifo_head;
  logic [31:0] status;

  logic unused_addr;
  assign unused_addr = ^bus_addr_in[1:0];

  assign region  = decode_region(bus_addr_in[31:2], RAM_WORDS);
  assign ram_idx = bus_addr_in[2 +: RamAw];

  // Routed through a net so the RAM array stays a plain clocked store without reset.
  assign ram_we = bus_mem_write && (region == RegRam) && !rst;

  // Console queue
  assign tx_push_req = bus_mem_write && (region == RegTxData) && bus_byteen[0];
  assign fifo_pop    = !fifo_empty && tx_ready;
  assign fifo_push   = tx_push_req && (!fifo_full || fifo_pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .data_i  (bus_data_in[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_head;
  assign timer_irq = irq_q;
  assign bus_error = err_q;

  always_comb begin
    status                 = '0;
    status[StatusEmptyBit] = fifo_empty;
    status[StatusFullBit]  = fifo_full;
    status[StatusIrqBit]   = irq_q;
    status[StatusOvfBit]   = ovf_q;
  end

  // Next-state for timer, shadow, compare, sticky overflow and error pulse.
  always_comb begin
    mtime_d  = mtime_q + 64'd1;
    shadow_d = shadow_q;
    cmp_d    = cmp_q;
    irq_d    = (mtime_q >= cmp_q);
    err_d    = (bus_mem_read || bus_mem_write) &&
               ((region == RegNone) || (bus_mem_read && bus_mem_write));
    ovf_d    = ovf_q;

    // The high word is captured alongside the low-word read so a lo/hi pair is coherent.
    if (bus_mem_read && (region == RegMtimeLo)) begin
      shadow_d = mtime_q[63:32];
    end

    if (bus_mem_write && (region == RegCmpLo)) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_byteen[i]) cmp_d[8*i +: 8] = bus_data_in[8*i +: 8];
      end
    end
    if (bus_mem_write && (region == RegCmpHi)) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_byteen[i]) cmp_d[32 + 8*i +: 8] = bus_data_in[8*i +: 8];
      end
    end

    // Set has priority over a software clear in the same cycle.
    if (tx_push_req && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (bus_mem_write && (region == RegStatus) && bus_byteen[0] &&
                 bus_data_in[StatusOvfBit]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q  <= '0;
      shadow_q <= '0;
      cmp_q    <= '1;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      shadow_q <= shadow_d;
      cmp_q    <= cmp_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_byteen[i]) ram_q[ram_idx][8*i +: 8] <= bus_data_in[8*i +: 8];
      end
    end
  end

  // Zero-latency read mux; TXDATA and unmapped read as zero.
  always_comb begin
    bus_data_out = '0;
    if (bus_mem_read) begin
      case (region)
        RegRam:     bus_data_out        = ram_q[ram_idx];
        RegStatus:  bus_data_out[31:0]  = status;
        RegMtimeLo: bus_data_out[31:0]  = mtime_q[31:0];
        RegMtimeHi: bus_data_out[31:0]  = shadow_q;
        RegCmpLo:   bus_data_out[31:0]  = cmp_q[31:0];
        RegCmpHi:   bus_data_out[31:0]  = cmp_q[63:32];
        default:    bus_data_out        = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

  localparam int unsigned FifoDepth = 4;
  localparam int RNone = -1, RRam = 0, RTx = 1, RSt = 2, RMlo = 3, RMhi = 4, RClo = 5, RChi = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        tx_ready;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, timer_irq, bus_error;

  always #5 clk = ~clk;

  data_bus_responder #(
    .WIDTH      (32),
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (FifoDepth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_mem_read  (rd),
    .bus_mem_write (wr),
    .bus_addr_in   (addr),
    .bus_data_in   (wdata),
    .bus_byteen    (be),
    .bus_data_out  (rdata),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .timer_irq     (timer_irq),
    .bus_error     (bus_error)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0]  ram_b [int];
  logic [7:0]  q_m [$];
  logic [63:0] mtime_m, cmp_m;
  logic [31:0] shadow_m;
  bit          ovf_m, irq_m, err_m;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic int region_of(input logic [31:0] a);
    if (a < 32'd4096) return RRam;
    case (a & 32'hFFFF_FFFC)
      32'h1000_0000: return RTx;
      32'h1000_0004: return RSt;
      32'h1000_0008: return RMlo;
      32'h1000_000C: return RMhi;
      32'h1000_0010: return RClo;
      32'h1000_0014: return RChi;
      default:       return RNone;
    endcase
  endfunction

  task automatic model_reset();
    q_m.delete();
    mtime_m  = 64'd0;
    cmp_m    = {64{1'b1}};
    shadow_m = 32'd0;
    ovf_m    = 0;
    irq_m    = 0;
    err_m    = 0;
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int r;
    int base;
    r = region_of(a);
    known = 1;
    v = 32'd0;
    case (r)
      RRam: begin
        base = int'(a >> 2) * 4;
        for (int i = 0; i < 4; i++) begin
          if (ram_b.exists(base + i)) v[8*i +: 8] = ram_b[base + i];
          else known = 0;
        end
      end
      RSt:  v = {28'd0, ovf_m, irq_m, q_m.size() == FifoDepth, q_m.size() == 0};
      RMlo: v = mtime_m[31:0];
      RMhi: v = shadow_m;
      RClo: v = cmp_m[31:0];
      RChi: v = cmp_m[63:32];
      default: v = 32'd0;
    endcase
  endtask

  task automatic model_edge();
    int r;
    bit pop, full, push_req, ovf_set;
    r = region_of(addr);
    err_m    = (rd || wr) && (r == RNone || (rd && wr));
    pop      = (q_m.size() != 0) && tx_ready;
    full     = (q_m.size() == FifoDepth);
    push_req = wr && (r == RTx) && be[0];
    ovf_set  = push_req && full && !pop;
    if (ovf_set) ovf_m = 1;
    else if (wr && r == RSt && be[0] && wdata[3]) ovf_m = 0;
    irq_m = (mtime_m >= cmp_m);
    if (rd && r == RMlo) shadow_m = mtime_m[63:32];
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (r == RClo) cmp_m[8*i +: 8] = wdata[8*i +: 8];
          if (r == RChi) cmp_m[32 + 8*i +: 8] = wdata[8*i +: 8];
          if (r == RRam) ram_b[int'(addr >> 2) * 4 + i] = wdata[8*i +: 8];
        end
      end
    end
    mtime_m = mtime_m + 64'd1;
    if (pop) void'(q_m.pop_front());
    if (push_req && !ovf_set) q_m.push_back(wdata[7:0]);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [31:0] exp;
    bit known;
    #1;
    if (rd) begin
      model_read(addr, exp, known);
      if (known) chk("rdata_model", rdata, exp);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("tx_valid", tx_valid, q_m.size() != 0);
    chk("tx_data", tx_data, (q_m.size() != 0) ? q_m[0] : 8'h00);
    chk("timer_irq", timer_irq, irq_m);
    chk("bus_error", bus_error, err_m);
    @(negedge clk);
  endtask

  task automatic idle();
    rd = 0; wr = 0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    rd = 0; wr = 1; addr = a; wdata = d; be = b;
  endtask

  task automatic set_rd(input logic [31:0] a);
    rd = 1; wr = 0; addr = a; wdata = 32'd0; be = 4'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h00BB_00DD};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'h0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         4'h0, 1'b1, 32'h00BB_00DD};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0016, 32'hCAFE_F00D, 4'hC, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 1'b1, 32'hCAFE_0000};
    tbl[8]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h1000_0004, 32'h0,         4'h0, 1'b1, 32'h0000_0001};
    tbl[10] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h1000_0018, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 32'h1000_0014, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF};
    tbl[14] = '{1'b1, 1'b1, 32'h0000_0018, 32'h0000_0055, 4'hF, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h0000_0018, 32'h0,         4'h0, 1'b1, 32'h0000_0055};
    tbl[16] = '{1'b0, 1'b1, 32'h1000_0008, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF};
    tbl[18] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0,         4'h0, 1'b0, 32'h0};

    tx_ready = 0;
    idle();
    rst = 0;
    @(negedge clk);
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timer_irq", timer_irq, 0);
    chk("rst_bus_error", bus_error, 0);

    // Directed vector table
    for (int k = 0; k < 19; k++) begin
      rd = tbl[k].rd; wr = tbl[k].wr; addr = tbl[k].addr; wdata = tbl[k].data; be = tbl[k].be;
      #1;
      if (tbl[k].chk) chk($sformatf("tbl%0d_rdata", k), rdata, tbl[k].exp);
      step();
    end
    idle();

    // Five pushes into a four-deep queue with the consumer stalled
    do_reset();
    tx_ready = 0;
    for (int k = 0; k < 5; k++) begin
      set_wr(32'h1000_0000, 32'h0000_0041 + k, 4'h1);
      step();
    end
    set_rd(32'h1000_0004);
    #1 chk("status_full_ovf", rdata, 32'h0000_000A);
    step();
    idle();
    tx_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("drain%0d", k), {tx_valid, tx_data}, {1'b1, 8'h41 + 8'(k)});
      step();
    end
    set_rd(32'h1000_0004);
    #1 chk("status_empty_ovf", rdata, 32'h0000_0009);
    step();
    set_wr(32'h1000_0004, 32'h0000_0008, 4'h1);
    step();
    set_rd(32'h1000_0004);
    #1 chk("status_ovf_clr", rdata, 32'h0000_0001);
    step();

    // Push into a full queue while it drains in the same cycle
    do_reset();
    tx_ready = 0;
    for (int k = 0; k < 4; k++) begin
      set_wr(32'h1000_0000, 32'h0000_0061 + k, 4'h1);
      step();
    end
    set_wr(32'h1000_0000, 32'h0000_0065, 4'h1);
    tx_ready = 1;
    step();
    tx_ready = 0;
    set_rd(32'h1000_0004);
    #1 chk("status_full_noovf", rdata, 32'h0000_0002);
    step();
    idle();
    tx_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("fullpush_drain%0d", k), {tx_valid, tx_data}, {1'b1, 8'h62 + 8'(k)});
      step();
    end

    // Timer compare at 5: irq visible after the sixth edge out of reset
    do_reset();
    tx_ready = 0;
    set_wr(32'h1000_0010, 32'h0000_0005, 4'hF);
    step();
    set_wr(32'h1000_0014, 32'h0000_0000, 4'hF);
    step();
    idle();
    for (int e = 3; e <= 6; e++) begin
      step();
      if (e == 5) chk("irq_edge5", timer_irq, 0);
      if (e == 6) chk("irq_edge6", timer_irq, 1);
    end
    set_rd(32'h1000_0004);
    #1 chk("status_irq", rdata, 32'h0000_0005);
    step();
    set_rd(32'h1000_0008);
    step();
    set_rd(32'h1000_000C);
    #1 chk("mtime_hi_shadow", rdata, 32'h0);
    step();

    // Unmapped access error pulse
    set_rd(32'h2000_0000);
    #1 chk("unmapped_rdata", rdata, 32'h0);
    step();
    chk("err_pulse", bus_error, 1);
    idle();
    step();
    chk("err_clear", bus_error, 0);

    // Reset asserted across a RAM write blocks it
    set_wr(32'h0000_0020, 32'h1111_1111, 4'hF);
    step();
    set_wr(32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
    rst = 1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    do_reset();
    set_rd(32'h0000_0020);
    #1 chk("rst_blocks_write", rdata, 32'h1111_1111);
    step();

    // Asynchronous reset mid-stream empties the queue without a clock edge
    tx_ready = 0;
    set_wr(32'h1000_0000, 32'h0000_00A5, 4'h1);
    step();
    step();
    idle();
    chk("pre_rst_valid", tx_valid, 1);
    #2 rst = 1;
    #1 chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_data", tx_data, 0);
    do_reset();
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        3: addr = 32'h1000_0000 | $urandom_range(0, 3);
        4: addr = 32'h1000_0004;
        5: addr = 32'h1000_0008;
        6: addr = 32'h1000_000C;
        7: addr = 32'h1000_0010 | $urandom_range(0, 3);
        8: addr = 32'h1000_0014;
        default: begin
          case ($urandom_range(0, 2))
            0: addr = 32'h2000_0000;
            1: addr = 32'h1000_0018;
            default: addr = 32'h0000_1000;
          endcase
        end
      endcase
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      if (sel == 7 || sel == 8) wdata = $urandom_range(0, 600);
      be = 4'($urandom_range(0, 15));
      tx_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address bus width.
REQ-002 SHALL have parameter RAM_WORDS, default 1024, RAM depth in WIDTH-bit words (power of two).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, console TX FIFO entries (power of two).
REQ-004 SHALL have ports: clk  in  1  clock, single domain, rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: bus_mem_read  in  1  read strobe from core.
REQ-007 SHALL have ports: bus_mem_write  in  1  write strobe from core.
REQ-008 SHALL have ports: bus_addr_in  in  WIDTH  byte address.
REQ-009 SHALL have ports: bus_data_in  in  WIDTH  write data.
REQ-010 SHALL have ports: bus_byteen  in  4  byte-lane enables, bit i = bits 8i+7:8i.
REQ-011 SHALL have ports: bus_data_out  out  WIDTH  read data.
REQ-012 SHALL have ports: tx_data  out  8, tx_valid  out  1, tx_ready  in  1  console byte stream.
REQ-013 SHALL have ports: timer_irq  out  1  timer interrupt level; bus_error  out  1  error pulse.

Function
REQ-014 SHALL decode on bus_addr_in[31:2]: RAM at 0x0000_0000..4*RAM_WORDS-1; MMIO at 0x1000_0000 (TXDATA), 0x1000_0004 (STATUS), 0x1000_0008/0C (MTIME lo/hi), 0x1000_0010/14 (MTIMECMP lo/hi); all else unmapped.
REQ-015 SHALL return read data combinationally (zero latency) while bus_mem_read=1; bus_data_out=0 when bus_mem_read=0 or address unmapped.
REQ-016 SHALL commit writes at the rising clk edge while bus_mem_write=1, updating only lanes with bus_byteen set; bus_byteen=0 is a no-op.
REQ-017 SHALL ignore bus_addr_in[1:0] for decode; lane selection is by bus_byteen only.
REQ-018 SHALL push bus_data_in[7:0] into the TX FIFO on a TXDATA write with bus_byteen[0]=1; TXDATA reads return 0.
REQ-019 SHALL drop a push when FIFO full and not popping that cycle, and set sticky STATUS.ovf.
REQ-020 SHALL accept push when full and pop occur in the same cycle (count unchanged); push+pop when empty SHALL NOT bypass (byte appears next cycle).
REQ-021 SHALL drive tx_valid=!empty, tx_data=head entry; pop when tx_valid&&tx_ready; tx_data stable while tx_valid&&!tx_ready.
REQ-022 SHALL read STATUS as {ovf[3], irq[2], full[1], empty[0]}, upper bits 0; writing 1 to bit 3 with bus_byteen[0] SHALL clear ovf (set wins if same cycle).
REQ-023 SHALL increment 64-bit MTIME every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0; MTIME writes ignored.
REQ-024 SHALL on a MTIME-lo read return live low word and latch live high word into a shadow at that clk edge; MTIME-hi reads return the shadow.
REQ-025 SHALL write MTIMECMP lo/hi per-lane; timer_irq SHALL be registered (MTIME >= MTIMECMP), one-cycle lag.
REQ-026 SHALL pulse bus_error for one cycle after an edge where: unmapped access, or bus_mem_read&&bus_mem_write both 1 (write then still performed if mapped).

Reset
REQ-027 SHALL on rst: FIFO empty, tx_valid=0, tx_data=0, ovf=0, MTIME=0, shadow=0, MTIMECMP=all ones, timer_irq=0, bus_error=0.
REQ-028 SHALL leave RAM contents untouched by rst; reset asserted mid-write SHALL block that write, and FIFO contents SHALL be discarded.

Structure
REQ-029 SHALL place address-map constants and STATUS bit indices in shared package bus_pkg.
REQ-030 SHALL instantiate one sub-module sync_fifo (WIDTH 8, FIFO_DEPTH) for the console queue.

Verification
REQ-031 SHALL cover: write 0xAABBCCDD byteen=4'b0101 to RAM 0x10 over 0 -> read 0x00BB00DD.
REQ-032 SHALL cover: 5 TXDATA pushes, tx_ready=0 -> 4 queued, STATUS=0x0000_000A; tx_ready=1 -> bytes out in order, STATUS=0x0000_0009.
REQ-033 SHALL cover: FIFO full, push with tx_ready=1 same cycle -> accepted, ovf stays 0.
REQ-034 SHALL cover: MTIMECMP=5 after reset -> timer_irq rises at cycle 6, STATUS bit2=1.
REQ-035 SHALL cover: read 0x2000_0000 -> bus_data_out=0, bus_error high one cycle; rst mid-stream -> tx_valid=0 immediately.
